// File: rtl/mio_arbiter_if.sv
// Request/response bundle for one bus master of the memory/IO arbiter.
// The master modport is the requester side; slave is the arbiter side.
interface mio_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mio_arbiter.sv
// Two-master round-robin arbiter sharing one synchronous memory port
// between the CPU and a DMA fetch master. One access per transaction,
// fixed memory latency, one-cycle ready pulse to the granted master.
module mio_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  mio_arbiter_if.slave      cpu,
  mio_arbiter_if.slave      dma,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant_dma;

  // State and datapath registers; reset leaves last_owner at DMA so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Next-state: grant in IDLE, single strobe in ISSUE, latency count in WAIT, ready in DONE
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    grant_dma    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu.req || dma.req) begin
          // DMA wins only when alone or when the CPU held the previous grant
          grant_dma    = dma.req && (!cpu.req || !last_owner_q);
          owner_d      = grant_dma;
          last_owner_d = grant_dma;
          mem_we_d     = grant_dma ? dma.we    : cpu.we;
          mem_addr_d   = grant_dma ? dma.addr  : cpu.addr;
          mem_wdata_d  = grant_dma ? dma.wdata : cpu.wdata;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!mem_we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dma.rdata = dma_rdata_q;
  assign cpu.ready = (state_q == S_DONE) && !owner_q;
  assign dma.ready = (state_q == S_DONE) &&  owner_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Scoreboard bench for mio_arbiter with MEM_LAT=2: expected accesses are
// queued as requests are driven, checked at mem_en and again at ready.
module tb_mio_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  mio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

  mio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .dma       (dma_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents as seen by the bus
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_1234);
  endfunction

  // Memory model: read data valid LAT cycles after the mem_en cycle, noise otherwise
  logic        st_v = 1'b0;
  logic [31:0] st_d = '0;
  always @(posedge clk) begin
    st_v      <= mem_en && !mem_we;
    st_d      <= rd_fn(mem_addr);
    mem_rdata <= st_v ? st_d : $urandom;
  end

  typedef struct {
    logic        dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        pend_q[$];
  logic [31:0] cpu_sh = '0;
  logic [31:0] dma_sh = '0;
  int          last_rdy = -100;

  // Scoreboard monitor
  always @(negedge clk) begin
    txn_t t;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      cpu_sh   = '0;
      dma_sh   = '0;
      last_rdy = -100;
    end else begin
      if (cpu_if.ready && dma_if.ready) chk("dual_ready", 1, 0);
      if (cyc == last_rdy + 1) chk("idle_after_done", busy, 0);
      if (mem_en) begin
        if (exp_q.size() == 0) chk("spurious_en", 1, 0);
        else begin
          t = exp_q.pop_front();
          chk("en_owner", owner, t.dma);
          chk("en_we", mem_we, t.we);
          chk("en_addr", mem_addr, t.addr);
          if (t.we) chk("en_wdata", mem_wdata, t.wdata);
          chk("en_busy", busy, 1);
          t.en_cyc = cyc;
          pend_q.push_back(t);
        end
      end
      if (cpu_if.ready || dma_if.ready) begin
        if (pend_q.size() == 0) chk("spurious_rdy", 1, 0);
        else begin
          t = pend_q.pop_front();
          chk("rdy_who", dma_if.ready, t.dma);
          chk("rdy_lat", cyc - t.en_cyc, LAT + 1);
          chk("done_addr", mem_addr, t.addr);
          chk("done_we", mem_we, t.we);
          if (t.we) chk("done_wdata", mem_wdata, t.wdata);
          else if (t.dma) dma_sh = t.rdata;
          else cpu_sh = t.rdata;
          chk("cpu_rdata", cpu_if.rdata, cpu_sh);
          chk("dma_rdata", dma_if.rdata, dma_sh);
          last_rdy = cyc;
        end
      end
    end
  end

  task automatic push_exp(input logic is_dma, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    txn_t t;
    t.dma = is_dma; t.we = we; t.addr = addr; t.wdata = wdata;
    t.rdata = rd_fn(addr); t.en_cyc = 0;
    exp_q.push_back(t);
  endtask

  task automatic drive(input logic is_dma, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (is_dma) begin
      dma_if.req = req; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata;
    end else begin
      cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
  endtask

  task automatic wait_en(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_en) begin seen = 1; break; end
    end
    if (!seen) chk("timeout_en", 0, 1);
  endtask

  // Lone request: ready expected exp_lat cycles after the sampling cycle
  task automatic do_single(input logic is_dma, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat);
    int  t0;
    bit  got = 0;
    push_exp(is_dma, we, addr, wdata);
    @(posedge clk); #1;
    drive(is_dma, 1'b1, we, addr, wdata);
    t0 = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (is_dma ? dma_if.ready : cpu_if.ready) begin got = 1; break; end
    end
    if (!got) chk("timeout_rdy", 0, 1);
    else chk("req_to_rdy", cyc - t0, exp_lat);
    @(posedge clk); #1;
    drive(is_dma, 1'b0, we, addr, wdata);
  endtask

  task automatic wait_readies(input int n, input int gap, input int budget);
    int cnt = 0;
    int last = 0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      @(negedge clk);
      if (cpu_if.ready || dma_if.ready) begin
        if (cnt > 0) chk("rdy_gap", cyc - last, gap);
        last = cyc;
        cnt++;
      end
    end
    if (cnt < n) chk("timeout_multi", cnt, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {mem_en, mem_we, busy, owner, cpu_if.ready, dma_if.ready}, 6'b0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rd"}, cpu_if.rdata, 0);
    chk({tag, "_dma_rd"}, dma_if.rdata, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1; reset = 1'b0;

    // CPU read of 0x100
    do_single(1'b0, 1'b0, 32'h100, '0, LAT + 2);

    // Tie from reset: CPU first, then alternating
    pulse_reset();
    push_exp(1'b0, 1'b0, 32'h0000_0040, '0);
    push_exp(1'b1, 1'b0, 32'h0000_8000, '0);
    push_exp(1'b0, 1'b0, 32'h0000_0040, '0);
    push_exp(1'b1, 1'b0, 32'h0000_8000, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_8000, '0);
    wait_readies(4, LAT + 3, 60);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;

    // DMA write leaves both rdata registers alone
    do_single(1'b1, 1'b1, 32'h2000, 32'h1234_5678, LAT + 2);
    // CPU write too
    do_single(1'b0, 1'b1, 32'h3004, 32'hCAFE_F00D, LAT + 2);

    // CPU holds req: back-to-back, one IDLE cycle between
    push_exp(1'b0, 1'b0, 32'h300, '0);
    push_exp(1'b0, 1'b0, 32'h300, '0);
    push_exp(1'b0, 1'b0, 32'h300, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h300, '0);
    wait_readies(3, LAT + 3, 60);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;

    // Reset during WAIT of a DMA read
    push_exp(1'b1, 1'b0, 32'h5550, '0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h5550, '0);
    wait_en(20);
    @(posedge clk); #1;
    reset = 1'b1;
    dma_if.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    repeat (6) @(negedge clk);

    // Tie after reset grants CPU first
    push_exp(1'b0, 1'b0, 32'h0000_0abc, '0);
    push_exp(1'b1, 1'b0, 32'h0000_0def, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0abc, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0def, '0);
    wait_readies(2, LAT + 3, 40);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;

    // CPU drops req mid-WAIT: completes once, then stays idle
    push_exp(1'b0, 1'b0, 32'h440, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h440, '0);
    wait_en(20);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    wait_readies(1, 0, 20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stay_idle", {busy, mem_en}, 2'b00);
    end
    chk("queues_drained", exp_q.size() + pend_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
